// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL (low half) / DIVU sequencer driving a shared single-cycle ALU.
// Shift-add multiply and restoring divide, one ALU operation per compute cycle.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_q,
  output logic [WIDTH-1:0] res_r,
  output logic             res_ovf,
  output logic             res_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic             alu_nb,
  output logic             alu_ic,
  output logic             alu_na,
  output logic             alu_xo,
  output logic             alu_no,
  output logic             alu_sr,
  output logic             alu_ss,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cf
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_ADD = 3'd1,
    S_MUL_DBL = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: MUL accumulator / DIV partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;
  // opa: MUL multiplicand / DIV dividend-quotient shifter
  logic [WIDTH-1:0] opa_q, opa_d;
  // opb: MUL multiplier / DIV divisor
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rq_q, rq_d;
  logic [WIDTH-1:0] rr_q, rr_d;
  logic             rovf_q, rovf_d;
  logic             rerr_q, rerr_d;
  logic [WIDTH-1:0] div_t;
  logic             qbit;
  logic             last;

  assign div_t = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
  assign last  = (cnt_q == CNT_LAST);

  // ALU operand/control drive, decoded from registered state only
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_ci = 1'b0;
    alu_nb = 1'b0;
    alu_ic = 1'b0;
    alu_na = 1'b0;
    alu_xo = 1'b0;
    alu_no = 1'b0;
    alu_sr = 1'b0;
    alu_ss = 1'b0;
    case (state_q)
      S_MUL_ADD: begin
        alu_a = acc_q;
        alu_b = opa_q;
      end
      S_MUL_DBL: begin
        alu_a = opa_q;
        alu_b = opa_q;
      end
      S_DIV_SUB: begin
        alu_a  = div_t;
        alu_b  = opb_q;
        alu_ci = 1'b1;
        alu_nb = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ovf_d   = ovf_q;
    rq_d    = rq_q;
    rr_d    = rr_q;
    rovf_d  = rovf_q;
    rerr_d  = rerr_q;
    qbit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          opa_d = in_a;
          opb_d = in_b;
          if (!in_op) begin
            state_d = S_MUL_ADD;
          end else if (in_b != '0) begin
            state_d = S_DIV_SUB;
          end else begin
            rq_d    = '1;
            rr_d    = in_a;
            rovf_d  = 1'b0;
            rerr_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL_ADD: begin
        if (opb_q[0]) begin
          acc_d = alu_out;
          ovf_d = ovf_q | alu_cf;
        end
        state_d = S_MUL_DBL;
      end
      S_MUL_DBL: begin
        opa_d = alu_out;
        opb_d = opb_q >> 1;
        // a lost mcand bit only matters if a later multiplier bit would add it
        if ((opb_q >> 1) != '0) begin
          ovf_d = ovf_q | alu_cf;
        end
        if (last) begin
          rq_d    = acc_q;
          rr_d    = '0;
          rovf_d  = ovf_d;
          rerr_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_MUL_ADD;
        end
      end
      S_DIV_SUB: begin
        qbit  = alu_cf;
        acc_d = alu_cf ? alu_out : div_t;
        opa_d = {opa_q[WIDTH-2:0], qbit};
        if (last) begin
          rq_d    = opa_d;
          rr_d    = acc_d;
          rovf_d  = 1'b0;
          rerr_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      ovf_q   <= 1'b0;
      rq_q    <= '0;
      rr_q    <= '0;
      rovf_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ovf_q   <= ovf_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
      rovf_q  <= rovf_d;
      rerr_q  <= rerr_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res_q     = rq_q;
  assign res_r     = rr_q;
  assign res_ovf   = rovf_q;
  assign res_err   = rerr_q;

endmodule
